// File: rtl/comma_aligner.sv
// comma_aligner: K28.5 word aligner with lock acquisition/loss tracking.
// Optional SYMBOL_CHECK_EN adds ones-count code checking and error-driven unlock.
module comma_aligner #(
  parameter int unsigned LOCK_COMMAS = 3,
  parameter int unsigned MAX_ERRS    = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Bit,
  input  logic       i_Bit_En,
  output logic [9:0] o_Symbol,
  output logic       o_Valid,
  output logic       o_Is_Comma,
  output logic       o_Lock,
  output logic       o_Code_Err
);

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_CONF = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  localparam logic [9:0] K_RDM = 10'b0011111010;
  localparam logic [9:0] K_RDP = 10'b1100000101;

  localparam logic [3:0] LC = 4'(LOCK_COMMAS);

  if (LOCK_COMMAS < 1 || LOCK_COMMAS > 15) begin : g_bad_lc
    $error("LOCK_COMMAS out of range 1..15");
  end
  if (MAX_ERRS < 1 || MAX_ERRS > 15) begin : g_bad_me
    $error("MAX_ERRS out of range 1..15");
  end

  logic [9:0] r_sr;
  logic [3:0] r_bcnt;
  logic [3:0] r_ccnt;
  logic [1:0] r_state;
  logic [9:0] r_sym;
  logic       r_valid;
  logic       r_is_comma;
  logic       r_lock;

  logic [9:0] w_next_sr;
  logic       w_comma;
  logic       w_bnd;
  logic [3:0] w_ccnt_inc;
  logic [1:0] w_state_n;
  logic [3:0] w_ccnt_n;
  logic       w_realign;
  logic       w_emit;

  assign w_next_sr  = {r_sr[8:0], i_Bit};
  assign w_comma    = i_Bit_En &&
                      (w_next_sr == K_RDM || w_next_sr == K_RDP);
  assign w_bnd      = i_Bit_En && (r_bcnt == 4'd9);
  assign w_ccnt_inc = r_ccnt + 4'd1;

`ifdef SYMBOL_CHECK_EN
  localparam logic [3:0] ME = 4'(MAX_ERRS);

  logic [3:0] r_ecnt;
  logic       r_code_err;
  logic [3:0] w_ones;
  logic       w_bad;
  logic [3:0] w_ecnt_inc;
  logic [3:0] w_ecnt_n;
  logic       w_err;

  assign w_ones     = 4'($countones(w_next_sr));
  assign w_bad      = (w_ones < 4'd4) || (w_ones > 4'd6);
  assign w_ecnt_inc = r_ecnt + 4'd1;
`endif

  // Alignment FSM: comma realignment has priority over boundary handling
  always_comb begin
    w_state_n = r_state;
    w_ccnt_n  = r_ccnt;
    w_realign = 1'b0;
    w_emit    = 1'b0;
`ifdef SYMBOL_CHECK_EN
    w_ecnt_n  = r_ecnt;
    w_err     = 1'b0;
`endif
    if (i_Bit_En) begin
      unique case (r_state)
        S_HUNT: begin
          if (w_comma) begin
            w_realign = 1'b1;
            w_ccnt_n  = 4'd1;
            if (LC == 4'd1) begin
              w_state_n = S_LOCK;
              w_emit    = 1'b1;
            end else begin
              w_state_n = S_CONF;
            end
          end
        end
        S_CONF: begin
          if (w_comma) begin
            if (w_bnd) begin
              w_ccnt_n = w_ccnt_inc;
              if (w_ccnt_inc >= LC) begin
                w_state_n = S_LOCK;
                w_emit    = 1'b1;
              end
            end else begin
              w_ccnt_n  = 4'd1;
              w_realign = 1'b1;
            end
          end
        end
        S_LOCK: begin
          if (w_comma && !w_bnd) begin
            w_state_n = S_CONF;
            w_ccnt_n  = 4'd1;
            w_realign = 1'b1;
          end else if (w_bnd) begin
            w_emit = 1'b1;
`ifdef SYMBOL_CHECK_EN
            if (w_bad) begin
              w_err    = 1'b1;
              w_ecnt_n = w_ecnt_inc;
              if (w_ecnt_inc == ME) begin
                w_state_n = S_HUNT;
                w_ccnt_n  = 4'd0;
              end
            end else begin
              w_ecnt_n = 4'd0;
            end
`endif
          end
        end
        default: begin
          w_state_n = S_HUNT;
          w_ccnt_n  = 4'd0;
        end
      endcase
    end
  end

  // Shift register, counters, state and symbol output registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_sr       <= '0;
      r_bcnt     <= '0;
      r_ccnt     <= '0;
      r_state    <= S_HUNT;
      r_sym      <= '0;
      r_valid    <= 1'b0;
      r_is_comma <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_Bit_En) begin
        r_sr    <= w_next_sr;
        r_state <= w_state_n;
        r_ccnt  <= w_ccnt_n;
        r_lock  <= (w_state_n == S_LOCK);
        if (w_realign || w_bnd) begin
          r_bcnt <= 4'd0;
        end else begin
          r_bcnt <= r_bcnt + 4'd1;
        end
        if (w_emit) begin
          r_sym      <= w_next_sr;
          r_valid    <= 1'b1;
          r_is_comma <= w_comma;
        end
      end
    end
  end

`ifdef SYMBOL_CHECK_EN
  // Consecutive-error counter and per-symbol error flag
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_ecnt     <= '0;
      r_code_err <= 1'b0;
    end else if (i_Bit_En) begin
      if (w_state_n == S_LOCK) begin
        r_ecnt <= w_ecnt_n;
      end else begin
        r_ecnt <= 4'd0;
      end
      if (w_emit) begin
        r_code_err <= w_err;
      end
    end
  end

  assign o_Code_Err = r_code_err;
`else
  assign o_Code_Err = 1'b0;
`endif

  assign o_Symbol   = r_sym;
  assign o_Valid    = r_valid;
  assign o_Is_Comma = r_is_comma;
  assign o_Lock     = r_lock;

endmodule
